// File: rtl/dly_detect8.sv
// ============================================================================
// dly_detect8 : recovers and tracks the tap (0..MAX_DLY) of a tap-select delay line
// Rev 1.0
// ============================================================================
`default_nettype none

module dly_detect8 #(
  parameter  int WIDTH    = 8,
  parameter  int MAX_DLY  = 3,
  parameter  int LOCK_CNT = 4,
  parameter  int LOSS_CNT = 2,
  localparam int SW       = $clog2(MAX_DLY + 1)
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] ref_d,
  input  logic [WIDTH-1:0] dly_q,
  output logic [SW-1:0]    sel_det,
  output logic             locked,
  output logic             err
);

  localparam int MCW = $clog2(LOCK_CNT + 1);
  localparam int LCW = $clog2(LOSS_CNT + 1);
  localparam logic [MCW-1:0] C_LOCK = MCW'(LOCK_CNT);
  localparam logic [LCW-1:0] C_LOSS = LCW'(LOSS_CNT);
  localparam logic [SW-1:0]  C_FMAX = SW'(MAX_DLY);

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_hist [1:MAX_DLY];
  logic [MCW-1:0]   r_mc   [0:MAX_DLY];
  logic [LCW-1:0]   r_lc;
  logic [SW-1:0]    r_fill;
  logic [SW-1:0]    r_sel;
  logic             r_locked;
  logic             r_err;

  logic [WIDTH-1:0] w_tap    [0:MAX_DLY];
  logic [MCW-1:0]   w_mc_nxt [0:MAX_DLY];
  logic             w_lock_any;
  logic [SW-1:0]    w_lock_sel;
  logic             w_trk_match;

  assign w_tap[0] = ref_d;

  generate
    for (genvar g = 1; g <= MAX_DLY; g++) begin : g_tap
      assign w_tap[g] = r_hist[g];
    end
  endgenerate

  // Scan from the top so the lowest locking tap is the one that sticks.
  always_comb begin
    w_lock_any = 1'b0;
    w_lock_sel = '0;
    for (int k = MAX_DLY; k >= 0; k--) begin
      if ((r_fill >= SW'(k)) && (dly_q == w_tap[k]))
        w_mc_nxt[k] = (r_mc[k] == C_LOCK) ? r_mc[k] : r_mc[k] + 1'b1;
      else
        w_mc_nxt[k] = '0;
      if (w_mc_nxt[k] == C_LOCK) begin
        w_lock_any = 1'b1;
        w_lock_sel = SW'(k);
      end
    end
  end

  assign w_trk_match = (dly_q == w_tap[r_sel]);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state  <= ST_SEARCH;
      r_lc     <= '0;
      r_fill   <= '0;
      r_sel    <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      for (int k = 1; k <= MAX_DLY; k++) r_hist[k] <= '0;
      for (int k = 0; k <= MAX_DLY; k++) r_mc[k] <= '0;
    end else begin
      r_err <= 1'b0;
      if (clr) begin
        r_state  <= ST_SEARCH;
        r_locked <= 1'b0;
        r_lc     <= '0;
        r_fill   <= '0;
        for (int k = 0; k <= MAX_DLY; k++) r_mc[k] <= '0;
      end else if (en) begin
        r_hist[1] <= ref_d;
        for (int k = 2; k <= MAX_DLY; k++) r_hist[k] <= r_hist[k-1];
        if (r_fill != C_FMAX) r_fill <= r_fill + 1'b1;

        case (r_state)
          ST_SEARCH: begin
            for (int k = 0; k <= MAX_DLY; k++) r_mc[k] <= w_mc_nxt[k];
            if (w_lock_any) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
              r_sel    <= w_lock_sel;
            end
          end
          ST_LOCKED: begin
            if (w_trk_match) begin
              r_lc <= '0;
            end else if ((r_lc + 1'b1) == C_LOSS) begin
              // History survives loss of lock so the search can resume at once.
              r_state  <= ST_SEARCH;
              r_locked <= 1'b0;
              r_err    <= 1'b1;
              r_lc     <= '0;
              for (int k = 0; k <= MAX_DLY; k++) r_mc[k] <= '0;
            end else begin
              r_lc <= r_lc + 1'b1;
            end
          end
          default: r_state <= ST_SEARCH;
        endcase
      end
    end
  end

  assign sel_det = r_sel;
  assign locked  = r_locked;
  assign err     = r_err;

endmodule

`default_nettype wire
